// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUT   = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a channel index.
    function automatic logic [NUM_OUT-1:0] sel_decode(input sel_t sel);
        logic [NUM_OUT-1:0] onehot;
        onehot = {NUM_OUT{1'b0}};
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding register with valid/ready
// handshake and a saturating count of delivered words.
module demux_slot #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [CNT_W-1:0]  cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic drain_s;

    // A word leaves only when one is actually held; ready on an empty slot is ignored.
    always_comb begin
        drain_s = valid & ready;
    end

    // Holding register: a load wins over a drain so drain+reload keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= {DATA_W{1'b0}};
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain_s) begin
            data  <= data;
            valid <= 1'b0;
        end else begin
            data  <= data;
            valid <= valid;
        end
    end

    // Delivered-word counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {CNT_W{1'b0}};
        end else if (drain_s && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted input word is
// steered by in_sel into one of four independent single-entry channels.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*CNT_W-1:0]  out_cnt
);

    sel_t               sel_s;
    logic               accept_s;
    logic [NUM_OUT-1:0] load_s;
    logic [NUM_OUT-1:0] valid_s;

    assign sel_s = in_sel;

    // Input is taken when the target channel is empty or draining this cycle;
    // in_valid is deliberately kept out of the ready path.
    always_comb begin
        in_ready = ~valid_s[sel_s] | out_ready[sel_s];
    end

    // Steer the accept strobe to exactly one channel.
    always_comb begin
        accept_s = in_valid & in_ready;
        load_s   = sel_decode(sel_s) & {NUM_OUT{accept_s}};
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_slot
            demux_slot #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load_s[g]),
                .load_data (in_data),
                .ready     (out_ready[g]),
                .data      (out_data[g*DATA_W +: DATA_W]),
                .valid     (valid_s[g]),
                .cnt       (out_cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign out_valid = valid_s;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream: a per-channel behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_demux1to4_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  in_data = 4'h0;
    logic [1:0]  in_sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [3:0]  out_ready = 4'b0000;

    logic        in_ready_a, in_ready_b;
    logic [15:0] out_data_a, out_data_b;
    logic [3:0]  out_valid_a, out_valid_b;
    logic [31:0] out_cnt_a;
    logic [7:0]  out_cnt_b;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // model state: per channel holding word, full flag, delivered count
    bit   m_full [4];
    logic [3:0] m_word [4];
    int   m_cnt  [4];

    demux1to4_stream #(.DATA_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_cnt(out_cnt_a)
    );

    demux1to4_stream #(.DATA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_cnt(out_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer moves the word out, an accepted word lands in the chosen channel.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 1'b0; m_word[i] = 4'h0; m_cnt[i] = 0;
            end
        end else begin
            bit take;
            take = in_valid && (!m_full[in_sel] || out_ready[in_sel]);
            for (int i = 0; i < 4; i++) begin
                if (m_full[i] && out_ready[i]) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    m_full[i] = 1'b0;
                end
            end
            if (take) begin
                m_full[in_sel] = 1'b1;
                m_word[in_sel] = in_data;
            end
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0]  e_valid;
            logic [15:0] e_data;
            logic [31:0] e_cnt_a;
            logic [7:0]  e_cnt_b;
            logic        e_rdy;
            for (int i = 0; i < 4; i++) begin
                e_valid[i] = m_full[i];
                e_data[i*4 +: 4] = m_word[i];
                e_cnt_a[i*8 +: 8] = 8'((m_cnt[i] > 255) ? 255 : m_cnt[i]);
                e_cnt_b[i*2 +: 2] = 2'((m_cnt[i] > 3) ? 3 : m_cnt[i]);
            end
            e_rdy = !m_full[in_sel] || out_ready[in_sel];
            chk("cyc_in_ready_a", 64'(in_ready_a), 64'(e_rdy));
            chk("cyc_in_ready_b", 64'(in_ready_b), 64'(e_rdy));
            chk("cyc_valid_a", 64'(out_valid_a), 64'(e_valid));
            chk("cyc_valid_b", 64'(out_valid_b), 64'(e_valid));
            chk("cyc_data_a", 64'(out_data_a), 64'(e_data));
            chk("cyc_data_b", 64'(out_data_b), 64'(e_data));
            chk("cyc_cnt_a", 64'(out_cnt_a), 64'(e_cnt_a));
            chk("cyc_cnt_b", 64'(out_cnt_b), 64'(e_cnt_b));
        end
    end

    // in_sel must be known whenever in_valid is asserted.
    always @(posedge clk) begin
        if (rst_n && in_valid && $isunknown(in_sel)) begin
            failures++;
            $display("FAIL sel_known actual=%b required=known t=%0t", in_sel, $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        #1;
        // reset state
        chk("rst_valid", 64'(out_valid_a), 64'h0);
        chk("rst_cnt", 64'(out_cnt_a), 64'h0);
        chk("rst_in_ready", 64'(in_ready_a), 64'h1);

        // route word A to channel 2
        drive(1'b1, 2'd2, 4'hA, 4'b1111);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        chk("route_valid", 64'(out_valid_a), 64'h4);
        chk("route_data", 64'(out_data_a[11:8]), 64'hA);
        step();
        chk("route_drained", 64'(out_valid_a), 64'h0);
        chk("route_cnt2", 64'(out_cnt_a[23:16]), 64'h1);
        chk("route_hold", 64'(out_data_a[11:8]), 64'hA);

        // back-pressure on channel 1
        drive(1'b1, 2'd1, 4'h3, 4'b1101);
        step();
        drive(1'b1, 2'd1, 4'h7, 4'b1101);
        chk("bp_stall", 64'(in_ready_a), 64'h0);
        step();
        chk("bp_held", 64'(out_data_a[7:4]), 64'h3);
        chk("bp_still_stall", 64'(in_ready_a), 64'h0);
        drive(1'b1, 2'd1, 4'h7, 4'b1111);
        chk("bp_release", 64'(in_ready_a), 64'h1);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        chk("bp_second", 64'(out_data_a[7:4]), 64'h7);
        chk("bp_cnt1", 64'(out_cnt_a[15:8]), 64'h1);
        step();
        chk("bp_cnt1_done", 64'(out_cnt_a[15:8]), 64'h2);

        // drain + reload on channel 3
        drive(1'b1, 2'd3, 4'h9, 4'b0111);
        step();
        drive(1'b1, 2'd3, 4'h5, 4'b1111);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        chk("dr_valid3", 64'(out_valid_a[3]), 64'h1);
        chk("dr_data3", 64'(out_data_a[15:12]), 64'h5);
        chk("dr_cnt3", 64'(out_cnt_a[31:24]), 64'h1);
        step();
        chk("dr_hold3", 64'(out_valid_a[3]), 64'h1);

        // saturation: five deliveries on channel 0
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd0, 4'(k + 1), 4'b1111);
            step();
        end
        chk("sat_4th", 64'(out_cnt_b[1:0]), 64'h3);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        step();
        chk("sat_5th", 64'(out_cnt_b[1:0]), 64'h3);
        chk("sat_wide", 64'(out_cnt_a[7:0]), 64'h5);

        // reset with all four channels full
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 4'(k + 8), 4'b0000);
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        chk("full_all", 64'(out_valid_a), 64'hF);
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid_a), 64'h0);
        chk("rst_async_data", 64'(out_data_a), 64'h0);
        chk("rst_async_cnt", 64'(out_cnt_a), 64'h0);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("rst_after_cnt", 64'(out_cnt_a), 64'h0);
        chk("rst_after_valid", 64'(out_valid_a), 64'h0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
